// File: rtl/mac_pkg.sv
// mac_pkg: register map of the mac slave and the feeder FSM state type.
package mac_pkg;
    localparam int OPS_BASE    = 0;
    localparam int CTRL_ADDR   = 8;
    localparam int STATUS_ADDR = 9;
    localparam int RESULT_ADDR = 10;
    localparam int DONE_BIT    = 0;
    typedef enum logic [2:0] {
        IDLE, WR_OPS, WR_GO, POLL_RD, POLL_DATA, RES_RD, RES_DATA, OUT
    } feeder_state_t;
endpackage

// File: rtl/mac_feeder.sv
// mac_feeder: Avalon-MM master that loads mac operands, starts a job, polls done and streams out the result.
module mac_feeder
    import mac_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 17,
    parameter int N_OPS       = 8,
    parameter int OPS_BASE    = mac_pkg::OPS_BASE,
    parameter int CTRL_ADDR   = mac_pkg::CTRL_ADDR,
    parameter int STATUS_ADDR = mac_pkg::STATUS_ADDR,
    parameter int RESULT_ADDR = mac_pkg::RESULT_ADDR,
    parameter int POLL_MAX    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic [DATA_W-1:0] snk_data,
    output logic              avm_chipselect,
    output logic              avm_read,
    output logic              avm_write,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              busy,
    output logic              timeout
);
    localparam int IDX_W = $clog2(N_OPS + 1);
    localparam int PC_W  = $clog2(POLL_MAX + 1);
    feeder_state_t     state;
    logic [IDX_W-1:0]  idx;
    logic [PC_W-1:0]   pc;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              in_ops;
    // Operand writes pass the sink stream straight through; every other request is registered.
    assign in_ops         = state == WR_OPS;
    assign snk_ready      = in_ops && !avm_waitrequest;
    assign avm_write      = in_ops ? snk_valid : wr_q;
    assign avm_read       = rd_q;
    assign avm_chipselect = avm_read | avm_write;
    assign avm_address    = in_ops ? ADDR_W'(OPS_BASE) + ADDR_W'(idx) : addr_q;
    assign avm_writedata  = in_ops ? snk_data : wdata_q;
    assign busy           = state != IDLE;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            pc        <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            src_valid <= 1'b0;
            src_data  <= '0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                    pc  <= '0;
                    if (snk_valid) state <= WR_OPS;
                end
                WR_OPS: if (snk_valid && !avm_waitrequest) begin
                    idx <= idx + IDX_W'(1);
                    if (idx == IDX_W'(N_OPS - 1)) begin
                        state   <= WR_GO;
                        wr_q    <= 1'b1;
                        addr_q  <= ADDR_W'(CTRL_ADDR);
                        wdata_q <= DATA_W'(1);
                    end
                end
                WR_GO: if (!avm_waitrequest) begin
                    state  <= POLL_RD;
                    wr_q   <= 1'b0;
                    rd_q   <= 1'b1;
                    addr_q <= ADDR_W'(STATUS_ADDR);
                end
                POLL_RD: if (!avm_waitrequest) begin
                    state <= POLL_DATA;
                    rd_q  <= 1'b0;
                    if (pc != PC_W'(POLL_MAX)) pc <= pc + PC_W'(1);
                end
                POLL_DATA: begin
                    if (avm_readdata[DONE_BIT]) begin
                        state  <= RES_RD;
                        rd_q   <= 1'b1;
                        addr_q <= ADDR_W'(RESULT_ADDR);
                    end else if (pc == PC_W'(POLL_MAX)) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        state  <= POLL_RD;
                        rd_q   <= 1'b1;
                        addr_q <= ADDR_W'(STATUS_ADDR);
                    end
                end
                RES_RD: if (!avm_waitrequest) begin
                    state <= RES_DATA;
                    rd_q  <= 1'b0;
                end
                RES_DATA: begin
                    state     <= OUT;
                    src_valid <= 1'b1;
                    src_data  <= avm_readdata;
                end
                OUT: if (src_ready) begin
                    state     <= IDLE;
                    src_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: scoreboard bench with a behavioural mac slave; expected Avalon traffic and results are queued per job.
module tb_mac_feeder;
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [16:0] addr;
        logic [31:0] data;
    } av_t;

    logic        clk = 0;
    logic        reset;
    logic        snk_valid, snk_ready;
    logic [31:0] snk_data;
    logic        avm_chipselect, avm_read, avm_write;
    logic [16:0] avm_address;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;
    logic        src_valid, src_ready;
    logic [31:0] src_data;
    logic        busy, timeout;

    int          checks = 0, passed = 0, cyc = 0, t_first = 0, t_valid = 0;
    bit          stress = 0;
    bit          status_q[$];
    logic [31:0] result_val = 32'h0;
    av_t         exp_av[$];
    logic [31:0] exp_src[$];
    av_t         prev_req;
    bit          prev_stall = 0, prev_sv = 0;

    mac_feeder #(.POLL_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mac slave: readdata is valid the cycle after an accepted read; status bits above bit0 are noise
    always @(posedge clk) begin
        bit d;
        avm_waitrequest <= stress ? 1'($urandom_range(0, 1)) : 1'b0;
        if (avm_read && !avm_waitrequest) begin
            if (avm_address == 17'd9) begin
                d = 1'b0;
                if (status_q.size() > 0) d = status_q.pop_front();
                avm_readdata <= d ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            end else if (avm_address == 17'd10) avm_readdata <= result_val;
            else avm_readdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        av_t cur, e;
        if (reset) begin
            cur = {avm_read, avm_write, avm_address, avm_write ? avm_writedata : 32'h0};
            if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev_req));
            if (avm_chipselect !== (avm_read | avm_write)) chk("chipselect", 64'(avm_chipselect), 64'(avm_read | avm_write));
            if (avm_read && avm_write) chk("rd_wr_excl", 64'({avm_read, avm_write}), 64'b01);
            if (avm_chipselect && !avm_waitrequest) begin
                if (exp_av.size() == 0) begin
                    checks++;
                    $display("FAIL avalon_unexpected: got rd=%0b wr=%0b addr=%0d data=%h expected no request",
                             avm_read, avm_write, avm_address, avm_writedata);
                end else begin
                    e = exp_av.pop_front();
                    chk("avalon", 64'(cur), 64'(e));
                end
                if (avm_write && avm_address == 17'd0) t_first = cyc;
            end
            prev_stall = avm_chipselect && avm_waitrequest;
            prev_req   = cur;
            if (src_valid && !prev_sv) t_valid = cyc;
            prev_sv = src_valid;
            if (src_valid && src_ready) begin
                if (exp_src.size() == 0) begin
                    checks++;
                    $display("FAIL src_unexpected: got %h expected no result", src_data);
                end else chk("src_data", 64'(src_data), 64'(exp_src.pop_front()));
            end
        end else begin
            prev_stall = 0;
            prev_sv    = 0;
        end
    end

    task automatic send(input logic [31:0] d);
        int n = 0;
        snk_valid = 1'b1;
        snk_data  = d;
        do begin @(negedge clk); n++; end while (!snk_ready && n < 200);
        if (!snk_ready) begin
            checks++;
            $display("FAIL send_timeout: got snk_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic push_writes(input logic [31:0] first, input int n);
        for (int k = 0; k < n; k++) exp_av.push_back({1'b0, 1'b1, 17'(k), first + 32'(k)});
    endtask

    // Queue the expected traffic for one job, program the slave, then stream the operands.
    task automatic job(input logic [31:0] first, input int polls, input bit done, input logic [31:0] res);
        status_q = {};
        for (int i = 0; i < polls - 1; i++) status_q.push_back(1'b0);
        status_q.push_back(done);
        result_val = res;
        push_writes(first, 8);
        exp_av.push_back({1'b0, 1'b1, 17'd8, 32'd1});
        for (int i = 0; i < polls; i++) exp_av.push_back({1'b1, 1'b0, 17'd9, 32'h0});
        if (done) begin
            exp_av.push_back({1'b1, 1'b0, 17'd10, 32'h0});
            exp_src.push_back(res);
        end
        for (int k = 0; k < 8; k++) send(first + 32'(k));
        snk_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_av.size() == 0 && exp_src.size() == 0 && !busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            $display("FAIL %s_done: got %0d avalon/%0d results pending expected none", name, exp_av.size(), exp_src.size());
            exp_av = {};
            exp_src = {};
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0; snk_valid = 1'b0; snk_data = 32'h0; src_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 64'({snk_ready, avm_chipselect, avm_read, avm_write, src_valid, busy, timeout}), 64'h0);
        chk("rst_addr", 64'(avm_address), 64'h0);
        chk("rst_wdata", 64'(avm_writedata), 64'h0);
        chk("rst_src_data", 64'(src_data), 64'h0);
        @(posedge clk); #1 reset = 1'b1;

        job(32'd1, 1, 1'b1, 32'h0000_00CC);
        wait_idle("nominal");
        chk("latency", 64'(t_valid - t_first), 64'd13);

        stress = 1;
        job(32'd1, 1, 1'b1, 32'h0000_00CC);
        wait_idle("stress");
        stress = 0;

        job(32'h100, 4, 1'b1, 32'h0000_1234);
        wait_idle("slow_done");
        chk("timeout_clear", 64'(timeout), 64'd0);

        job(32'h200, 4, 1'b0, 32'h0);
        wait_idle("timeout");
        chk("timeout_set", 64'(timeout), 64'd1);
        chk("timeout_idle", 64'(busy), 64'd0);
        job(32'h300, 1, 1'b1, 32'h5555_AAAA);
        wait_idle("after_timeout");
        chk("timeout_sticky", 64'(timeout), 64'd1);

        src_ready = 1'b0;
        job(32'h400, 1, 1'b1, 32'h0000_ABCD);
        n = 0;
        while (!src_valid && n < 200) begin @(negedge clk); n++; end
        chk("bp_valid", 64'(src_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", 64'({src_valid, src_data, snk_ready, avm_chipselect}), 64'({1'b1, 32'h0000_ABCD, 1'b0, 1'b0}));
        end
        @(posedge clk); #1 src_ready = 1'b1;
        wait_idle("backpressure");

        push_writes(32'h500, 4);
        for (int k = 0; k < 4; k++) send(32'h500 + 32'(k));
        snk_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_ctrl", 64'({snk_ready, avm_chipselect, avm_read, avm_write, src_valid, busy}), 64'h0);
        chk("mid_rst_addr", 64'({avm_address, avm_writedata, src_data}), 64'h0);
        chk("mid_rst_writes", 64'(exp_av.size()), 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        job(32'h600, 1, 1'b1, 32'h0000_0777);
        wait_idle("post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/mac_feeder.md
# mac_feeder

Avalon-MM master stage directly upstream of the `mac` slave in the video-stream datapath. It collects operand words from a valid/ready input stream and writes each job into the mac operand registers. It then starts the mac, polls its status until done, reads the result back and presents it on a valid/ready output stream. Its master port connects one-to-one to the mac `avs_*` slave port: chipselect, read, write, address, writedata, readdata.

## Interface
Parameters:
- DATA_W, 32, operand/result word width
- ADDR_W, 17, Avalon address width (matches mac `avs_address`)
- N_OPS, 8, operand words per job (1..2^ADDR_W-3)
- OPS_BASE, 0, address of first operand register; operand k at OPS_BASE+k
- CTRL_ADDR, 8, mac control register; writing 1 starts a job
- STATUS_ADDR, 9, mac status register; bit0 = done
- RESULT_ADDR, 10, mac result register
- POLL_MAX, 1024, maximum status reads per job before timeout

Ports:
- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- snk_valid  in  1  operand word valid
- snk_ready  out  1  operand word accepted when high with snk_valid
- snk_data  in  DATA_W  operand word
- avm_chipselect  out  1  high whenever avm_read or avm_write is high
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_address  out  ADDR_W  word address
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data, valid exactly 1 cycle after an accepted read
- avm_waitrequest  in  1  slave stall; request held unchanged while high
- src_valid  out  1  result valid
- src_ready  in  1  downstream accepts result
- src_data  out  DATA_W  mac result
- busy  out  1  high in every state except IDLE
- timeout  out  1  sticky; set on poll timeout, cleared only by reset

## Operation
- States: IDLE, WR_OPS, WR_GO, POLL_RD, POLL_DATA, RES_RD, RES_DATA, OUT.
- IDLE: when snk_valid=1, go to WR_OPS in the same cycle. Operand index idx=0, poll count pc=0.
- WR_OPS:
  - avm_write = snk_valid; avm_address = OPS_BASE+idx; avm_writedata = snk_data.
  - snk_ready = !avm_waitrequest.
  - On transfer (snk_valid & snk_ready): idx++. If idx was N_OPS-1, go to WR_GO.
  - snk_ready is low in all other states.
- WR_GO: write 1 to CTRL_ADDR; hold until waitrequest low, then go to POLL_RD.
- POLL_RD: read STATUS_ADDR; hold until waitrequest low, then go to POLL_DATA and increment pc.
- POLL_DATA: sample avm_readdata[0]. Then:
  - if 1, go to RES_RD;
  - else if pc==POLL_MAX, set timeout, discard the job, go to IDLE;
  - else go to POLL_RD.
- RES_RD: read RESULT_ADDR; hold until waitrequest low, then go to RES_DATA.
- RES_DATA: capture avm_readdata into src_data, go to OUT.
- OUT: src_valid=1; src_data stable until src_ready. On handshake go to IDLE.
- Counters: idx is ceil(log2(N_OPS+1)) bits and never wraps within a job. pc saturates at POLL_MAX.
- Reset: all state is discarded mid-operation; no partial write is completed.

## Timing
- Reset values: state IDLE; snk_ready 0, avm_chipselect 0, avm_read 0, avm_write 0, avm_address 0, avm_writedata 0, src_valid 0, src_data 0, busy 0, timeout 0.
- All outputs are registered, except snk_ready and the WR_OPS pass-through of snk_data/snk_valid.
- Best-case latency:
  - Conditions: no waitrequest, snk_valid continuous, done on first poll.
  - Writes occupy cycles 0..N_OPS-1; go at N_OPS; poll at N_OPS+1/N_OPS+2; result at N_OPS+3/N_OPS+4.
  - src_valid rises at cycle N_OPS+5 (13 for N_OPS=8).
- Each waitrequest cycle adds exactly one cycle. Address and data stay constant during stalls.
- Back-to-back jobs: the first word of the next job is written no earlier than the cycle after the OUT handshake.
- At most one Avalon request is outstanding; read and write are never asserted together.

## Structure
- Shared package `mac_pkg` holds:
  - register-map constants OPS_BASE, CTRL_ADDR, STATUS_ADDR, RESULT_ADDR and the status done-bit index, shared with `mac`;
  - the state enum `feeder_state_t`.
- Single module; no sub-module is needed. The FSM, counters and result register live in one file.

## Test plan
- Nominal job: N_OPS=8, operands 1..8, no stalls, status done on first poll, result 0x000000CC → eight writes to addresses 0..7 with data 1..8, then write 1 to address 8, one read of address 9, one read of address 10; src_valid at cycle 13 with src_data=0x000000CC.
- Waitrequest stress: random waitrequest on every request → address/data held while high, no duplicate or missing writes, same result as the nominal job.
- Slow done: status returns 0 three times, then 1 → exactly four STATUS reads, then the RESULT read; timeout stays 0.
- Timeout: POLL_MAX=4, status never done → four status reads, timeout=1, return to IDLE, no src_valid; the next job still completes normally.
- Backpressure: src_ready low for 10 cycles in OUT → src_valid and src_data held, snk_ready 0, no Avalon traffic.
- Reset mid-job: reset low after the 4th operand write → all outputs return to reset values next cycle; a new 8-word job then writes starting at address 0.
